// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the pipeline core, the shared SRAM and
// mem_arbiter.
//   fetch port : i_oen, i_addr -> i_rdata, i_valid, i_stall
//   data port  : d_oen, d_wen, d_addr, d_wdata -> d_rdata, d_valid, d_stall
//   SRAM port  : mem_cen, mem_wen, mem_addr, mem_wdata <- mem_rdata
// modport slave  : arbiter view
// modport master : core + SRAM view (what a testbench drives)
interface mem_arbiter_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 32
);
  logic          i_oen;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          i_stall;

  logic          d_oen;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_stall;

  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_oen, i_addr, d_oen, d_wen, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
           mem_cen, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output i_oen, i_addr, d_oen, d_wen, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
           mem_cen, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port SRAM (read latency 1)
// between the instruction-fetch port and the data port.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave (fetch, data and SRAM signals)
// Data wins by default; after MAX_DSTREAK consecutive data grants with a
// fetch waiting, the fetch is forced through for one cycle.
module mem_arbiter #(
  parameter int unsigned AW          = 11,
  parameter int unsigned DW          = 32,
  parameter int unsigned MAX_DSTREAK = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned    SW   = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0]  SMAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_INSTR,
    TAG_DATA
  } tag_e;

  tag_e          tag_q, tag_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [DW-1:0] i_hold_q, i_hold_d;
  logic [DW-1:0] d_hold_q, d_hold_d;

  logic          ireq, dreq, dwrite;
  logic          igrant, dgrant;
  logic [AW-1:0] mem_addr_d;

  // Requests are masked during reset so that no grant or stall is visible
  // while rst_n is low.
  always_comb begin
    ireq   = rst_n & ~bus.i_oen;
    dreq   = rst_n & (~bus.d_oen | ~bus.d_wen);
    dwrite = ~bus.d_wen;
    dgrant = dreq & ~(ireq & (streak_q == SMAX));
    igrant = ireq & ~dgrant;
  end

  always_comb begin
    mem_addr_d = '0;
    if (dgrant)      mem_addr_d = bus.d_addr;
    else if (igrant) mem_addr_d = bus.i_addr;
  end

  assign bus.mem_cen   = ~(igrant | dgrant);
  assign bus.mem_wen   = ~(dgrant & dwrite);
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.i_stall   = ireq & ~igrant;
  assign bus.d_stall   = dreq & ~dgrant;

  always_comb begin
    tag_d = TAG_NONE;
    if (igrant)                tag_d = TAG_INSTR;
    else if (dgrant & ~dwrite) tag_d = TAG_DATA;
  end

  always_comb begin
    streak_d = streak_q;
    if (!ireq || igrant) begin
      streak_d = '0;
    end else if (dgrant) begin
      streak_d = (streak_q == SMAX) ? SMAX : streak_q + 1'b1;
    end
  end

  always_comb begin
    i_hold_d = i_hold_q;
    d_hold_d = d_hold_q;
    if (tag_q == TAG_INSTR) i_hold_d = bus.mem_rdata;
    if (tag_q == TAG_DATA)  d_hold_d = bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= TAG_NONE;
      streak_q <= '0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      tag_q    <= tag_d;
      streak_q <= streak_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

  // Returned data is forwarded straight from the SRAM in the valid cycle;
  // the hold registers keep it visible afterwards.
  assign bus.i_valid = (tag_q == TAG_INSTR);
  assign bus.d_valid = (tag_q == TAG_DATA);
  assign bus.i_rdata = (tag_q == TAG_INSTR) ? bus.mem_rdata : i_hold_q;
  assign bus.d_rdata = (tag_q == TAG_DATA)  ? bus.mem_rdata : d_hold_q;

endmodule
